// File: rtl/ram_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : ram_copy_engine
// Purpose  : Bus master for a single-port synchronous RAM. After a start pulse
//            it copies len consecutive words from src_addr to dst_addr. Each
//            word takes three cycles: read address (RD), data return (WAIT)
//            and write (WR). It reports busy/done/aborted and a word count.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            start, abort        - request (IDLE only) / cancel (busy only)
//            src_addr, dst_addr,
//            len                 - copy parameters, latched on accepted start
//            busy, done, aborted - status (done/aborted are 1-cycle pulses)
//            words_done          - words written in current/last copy
//            ram_addr, ram_din,
//            ram_rw, ram_dout    - RAM port (ram_rw: 1 = write)
// Revision : 1.0 - initial release
// ============================================================================
module ram_copy_engine #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W-1:0] words_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_rw,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_rd   = 3'd1;
    localparam logic [2:0] c_wait = 3'd2;
    localparam logic [2:0] c_wr   = 3'd3;
    localparam logic [2:0] c_fin  = 3'd4;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_idx;

    logic [ADDR_W-1:0] w_idx_nxt;
    logic              w_last;
    logic [ADDR_W-1:0] w_rd_addr_nxt;
    logic [ADDR_W-1:0] w_wr_addr;

    // Address sums wrap naturally modulo 2^ADDR_W.
    assign w_idx_nxt     = r_idx + ADDR_W'(1);
    assign w_last        = (w_idx_nxt == r_len);
    assign w_rd_addr_nxt = r_src + w_idx_nxt;
    assign w_wr_addr     = r_dst + r_idx;

    // Every output is a register that is loaded on the edge entering the
    // state in which it must be visible, so the RAM sees a clean Moore port.
    // ram_din doubles as the captured-data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_idle;
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            words_done <= '0;
            ram_addr   <= '0;
            ram_din    <= '0;
            ram_rw     <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (r_state)
                c_idle: begin
                    // abort is meaningless here; start always wins.
                    if (start) begin
                        r_src      <= src_addr;
                        r_dst      <= dst_addr;
                        r_len      <= len;
                        r_idx      <= '0;
                        words_done <= '0;
                        if (len != '0) begin
                            busy     <= 1'b1;
                            ram_addr <= src_addr;
                            r_state  <= c_rd;
                        end else begin
                            // Zero-length copy: report completion, no RAM access.
                            done    <= 1'b1;
                            r_state <= c_fin;
                        end
                    end
                end
                c_rd: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        r_state <= c_idle;
                    end else begin
                        r_state <= c_wait;
                    end
                end
                c_wait: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        r_state <= c_idle;
                    end else begin
                        ram_din  <= ram_dout;
                        ram_addr <= w_wr_addr;
                        ram_rw   <= 1'b1;
                        r_state  <= c_wr;
                    end
                end
                c_wr: begin
                    // The RAM commits the write on this edge, so it is counted
                    // even when abort is also present.
                    ram_rw     <= 1'b0;
                    words_done <= words_done + ADDR_W'(1);
                    r_idx      <= w_idx_nxt;
                    if (abort) begin
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        r_state <= c_idle;
                    end else if (w_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= c_fin;
                    end else begin
                        ram_addr <= w_rd_addr_nxt;
                        r_state  <= c_rd;
                    end
                end
                c_fin: begin
                    r_state <= c_idle;
                end
                default: begin
                    busy    <= 1'b0;
                    ram_rw  <= 1'b0;
                    r_state <= c_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
